// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 serializer: FSM states, RGB word
// field offsets and default 100 MHz timing.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned B_MSB = 7;

  localparam int unsigned T_BIT_DEFAULT   = 125;
  localparam int unsigned T0H_DEFAULT     = 40;
  localparam int unsigned T1H_DEFAULT     = 80;
  localparam int unsigned T_RESET_DEFAULT = 8000;

  // Strip wire order is G, R, B, each byte MSB first.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[G_MSB -: 8], rgb[R_MSB -: 8], rgb[B_MSB -: 8]};
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter: reports whether the current cycle is in the high part
// of the bit and strobes on the last cycle of each bit period.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT = T_BIT_DEFAULT,
  parameter int unsigned T0H   = T0H_DEFAULT,
  parameter int unsigned T1H   = T1H_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic bit_val,
  output logic high,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(T_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] T0H_C = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C = CNT_W'(T1H);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!run || bit_end) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_comb begin
    bit_end = run && (bit_cnt == LAST);
    high    = bit_cnt < (bit_val ? T1H_C : T0H_C);
  end

endmodule

// File: rtl/rgb_ws2812_serializer.sv
// Accepts {R,G,B} pixels over valid/ready and emits them GRB, MSB first, as a
// WS2812 pulse-width stream on dout, with an optional frame latch gap.
module rgb_ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT   = T_BIT_DEFAULT,
  parameter int unsigned T0H     = T0H_DEFAULT,
  parameter int unsigned T1H     = T1H_DEFAULT,
  parameter int unsigned T_RESET = T_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  input  logic        frame_end,
  output logic        dout,
  output logic        busy
);

  localparam int unsigned LAT_W = $clog2(T_RESET + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RESET - 1);

  state_t            state, state_next;
  logic [23:0]       shreg;
  logic [4:0]        bit_idx;
  logic [LAT_W-1:0]  latch_cnt;
  logic              latch_pending;
  logic              take, last_bit, latch_done, latch_entry;
  logic              bit_high, bit_end;
  logic              ready_next, dout_next;

  ws2812_bit_timer #(
    .T_BIT(T_BIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state == SHIFT),
    .bit_val(shreg[23]),
    .high   (bit_high),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    take       = (state == IDLE) && rgb_valid && rgb_ready;
    last_bit   = (state == SHIFT) && bit_end && (bit_idx == '0);
    latch_done = (state == LATCH) && (latch_cnt == LAT_LAST);
    state_next = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_next = SHIFT;
        end else if (latch_pending || frame_end) begin
          state_next = LATCH;
        end
      end
      // frame_end arriving on the final edge of a pixel still latches directly.
      SHIFT: if (last_bit) state_next = (latch_pending || frame_end) ? LATCH : IDLE;
      LATCH: if (latch_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    latch_entry = (state_next == LATCH) && (state != LATCH);
  end

  always_comb begin
    ready_next = (state_next == IDLE);
    dout_next  = (state == SHIFT) && bit_high;
    busy       = (state != IDLE) || latch_pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_ready <= 1'b0;
      dout      <= 1'b0;
    end else begin
      rgb_ready <= ready_next;
      dout      <= dout_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg         <= '0;
      bit_idx       <= '0;
      latch_cnt     <= '0;
      latch_pending <= 1'b0;
    end else begin
      if (take) begin
        shreg   <= rgb_to_grb(rgb_in);
        bit_idx <= 5'd23;
      end else if ((state == SHIFT) && bit_end) begin
        shreg   <= {shreg[22:0], 1'b0};
        bit_idx <= bit_idx - 5'd1;
      end

      if (latch_entry) begin
        latch_pending <= 1'b0;
      end else if (frame_end && ((state == SHIFT) || take)) begin
        latch_pending <= 1'b1;
      end

      latch_cnt <= ((state == LATCH) && !latch_done) ? latch_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_rgb_ws2812_serializer.sv
// Scoreboard bench for rgb_ws2812_serializer: the driver queues each pixel it
// hands over, the monitor decodes the dout waveform and compares.
module tb_rgb_ws2812_serializer;

  localparam int T_BIT   = 10;
  localparam int T0H     = 3;
  localparam int T1H     = 7;
  localparam int T_RESET = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_in = '0;
  logic        rgb_valid = 1'b0;
  logic        frame_end = 1'b0;
  logic        rgb_ready, dout, busy;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  bit latch_req = 1'b0;
  bit pending_ready = 1'b0;

  rgb_ws2812_serializer #(
    .T_BIT  (T_BIT),
    .T0H    (T0H),
    .T1H    (T1H),
    .T_RESET(T_RESET)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rgb_in   (rgb_in),
    .rgb_valid(rgb_valid),
    .rgb_ready(rgb_ready),
    .frame_end(frame_end),
    .dout     (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: k-th transmitted bit (0 = first on the wire) is G7..G0, R7..R0, B7..B0.
  function automatic int exp_high(input logic [23:0] rgb, input int k);
    logic [7:0] b;
    case (k / 8)
      0:       b = rgb[15:8];
      1:       b = rgb[23:16];
      default: b = rgb[7:0];
    endcase
    return b[7 - (k % 8)] ? T1H : T0H;
  endfunction

  task automatic watch_pixel(output bit ok_end);
    logic [23:0] word, got, want;
    int bad[24];
    int highs[24];
    int status_bad, latch_bad, k, c;
    bit lat;
    ok_end = 1'b0;
    if (exp_q.size() == 0) begin
      check("unexpected_handshake", 32'(exp_q.size()), 32'd1);
      return;
    end
    word = exp_q.pop_front();
    for (int j = 0; j < 24; j++) begin
      bad[j] = 0;
      highs[j] = 0;
    end
    status_bad = 0;
    for (int i = 0; i < 24 * T_BIT; i++) begin
      @(negedge clk);
      if (rst) return;
      if (rgb_ready !== 1'b0 || busy !== 1'b1) status_bad++;
      if (i == 0) begin
        if (dout !== 1'b0) status_bad++;
      end else begin
        k = (i - 1) / T_BIT;
        c = (i - 1) % T_BIT;
        if (dout !== ((c < exp_high(word, k)) ? 1'b1 : 1'b0)) bad[k]++;
        if (dout === 1'b1) highs[k]++;
      end
    end
    got = '0;
    for (int j = 0; j < 24; j++) begin
      check($sformatf("bit%0d_pulse", j), 32'(bad[j]), 32'd0);
      got = {got[22:0], (highs[j] * 2 > T0H + T1H)};
    end
    want = {word[15:8], word[23:16], word[7:0]};
    check("pixel_word_grb", {8'd0, got}, {8'd0, want});
    check("shift_ready_busy", 32'(status_bad), 32'd0);
    lat = latch_req;
    latch_req = 1'b0;
    if (lat) begin
      latch_bad = 0;
      for (int i = 0; i < T_RESET; i++) begin
        @(negedge clk);
        if (rst) return;
        if (dout !== 1'b0 || busy !== 1'b1 || rgb_ready !== 1'b0) latch_bad++;
      end
      check("latch_window", 32'(latch_bad), 32'd0);
    end
    ok_end = 1'b1;
  endtask

  initial begin : monitor
    bit ok;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending_ready = 1'b0;
        continue;
      end
      if (pending_ready) begin
        check("ready_after_pixel", {31'd0, rgb_ready}, 32'd1);
        pending_ready = 1'b0;
      end
      check("idle_dout_low", {31'd0, dout}, 32'd0);
      if (rgb_valid && rgb_ready) begin
        watch_pixel(ok);
        pending_ready = ok;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (rgb_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pixel(input logic [23:0] w, input bit fe, input bit hold);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    exp_q.push_back(w);
    rgb_in    = w;
    rgb_valid = 1'b1;
    frame_end = fe;
    if (fe) latch_req = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    if (!hold) rgb_valid = 1'b0;
  endtask

  task automatic pulse_frame_end_after(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    frame_end = 1'b1;
    latch_req = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : driver
    bit ok;
    int n, dhigh, bhigh, mode;
    logic [23:0] w;

    @(negedge clk);
    check("reset_ready", {31'd0, rgb_ready}, 32'd0);
    check("reset_dout", {31'd0, dout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    check("ready_before_first_edge", {31'd0, rgb_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge", {31'd0, rgb_ready}, 32'd1);

    send_pixel(24'hFF0000, 1'b0, 1'b0);

    send_pixel(24'h000001, 1'b0, 1'b1);
    send_pixel(24'h800000, 1'b0, 1'b0);

    send_pixel(24'h5A3C96, 1'b1, 1'b0);

    send_pixel(24'h0F1E2D, 1'b0, 1'b0);
    pulse_frame_end_after(1 + 5 * T_BIT + 1);

    send_pixel(24'hC3A55A, 1'b0, 1'b0);
    n = 0;
    while (rgb_ready !== 1'b1 && n < 400) begin
      rgb_in    = 24'($urandom);
      rgb_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    rgb_valid = 1'b0;

    wait_ready(ok);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    check("standalone_latch_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("standalone_latch_len", 32'(n), 32'(T_RESET));
    check("standalone_latch_ready", {31'd0, rgb_ready}, 32'd1);

    for (int it = 0; it < 6; it++) begin
      w = 24'($urandom);
      mode = $urandom_range(0, 2);
      send_pixel(w, mode == 1, 1'b0);
      if (mode == 2) pulse_frame_end_after($urandom_range(10, 200));
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
    end

    send_pixel(24'hFF0000, 1'b0, 1'b0);
    repeat (82) begin
      @(posedge clk); #1;
    end
    check("dout_high_before_rst", {31'd0, dout}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("dout_async_rst", {31'd0, dout}, 32'd0);
    check("busy_async_rst", {31'd0, busy}, 32'd0);
    latch_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    check("ready_low_after_release", {31'd0, rgb_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_high_after_release", {31'd0, rgb_ready}, 32'd1);
    dhigh = 0;
    bhigh = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (dout !== 1'b0) dhigh++;
      if (busy !== 1'b0) bhigh++;
    end
    check("no_residual_bits", 32'(dhigh), 32'd0);
    check("no_residual_busy", 32'(bhigh), 32'd0);

    repeat (5) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
